// File: rtl/uart_pkg.sv
// uart_pkg: shared types and helpers for the configurable UART receiver
package uart_pkg;
  typedef enum logic [1:0] {NONE, ODD, EVEN} parity_t;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, PUSH, BREAK_WAIT} rx_state_t;
  function automatic int calc_div(input int clk_hz, input int baud, input int os);
    return clk_hz / (baud * os);
  endfunction
  function automatic logic majority3(input logic [2:0] s);
    return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
  endfunction
endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: first-word-fall-through FIFO with occupancy count and drop flag
module uart_rx_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_wr,
  input  logic                     i_rd,
  input  logic [WIDTH-1:0]         i_data,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_valid,
  output logic                     o_drop,
  output logic [$clog2(DEPTH):0]   o_count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = DEPTH[AW:0];
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr, r_rd;
  logic [AW:0] r_count;
  logic w_push, w_pop;
  assign o_valid = r_count != '0;
  assign w_pop = i_rd && o_valid;
  // a pop in the same cycle frees the slot the full-FIFO write lands in
  assign w_push = i_wr && (r_count != FULL || w_pop);
  assign o_drop = i_wr && !w_push;
  assign o_data = o_valid ? r_mem[r_rd] : '0;
  assign o_count = r_count;
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wr] <= i_data;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_wr <= '0;
      r_rd <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop) r_rd <= r_rd + 1'b1;
      r_count <= r_count + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
    end
endmodule

// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: oversampled UART receiver with majority voting, error flags, break detect and output FIFO
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int BAUD_RATE   = 115200,
  parameter int DATA_BITS   = 8,
  parameter int PARITY      = 0,
  parameter int STOP_BITS   = 1,
  parameter int OVERSAMPLE  = 16,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          rx,
  output logic [DATA_BITS-1:0]          rx_data,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic                          rx_frame_err,
  output logic                          rx_parity_err,
  output logic                          rx_overrun,
  input  logic                          err_clear,
  output logic                          rx_break,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
  localparam int DIV = calc_div(CLK_FREQ_HZ, BAUD_RATE, OVERSAMPLE);
  localparam int DIVW = $clog2(DIV);
  localparam int OSW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  localparam parity_t P_MODE = parity_t'(PARITY);

  if (DIV < 2) begin : g_div_chk
    $error("uart_rx_cfg: clock divider below 2");
  end

  rx_state_t r_state, w_next;
  logic [1:0] r_sync, r_samp;
  logic [DIVW-1:0] r_div;
  logic [OSW-1:0] r_os;
  logic [BW-1:0] r_bit;
  logic [DATA_BITS-1:0] r_data;
  logic [DATA_BITS+1:0] w_head;
  logic r_par, r_par_err, r_frame_err, r_stop0, r_overrun;
  logic w_rx_s, w_start, w_tick, w_dec, w_maj, w_last, w_push, w_break, w_drop;

  assign w_rx_s = r_sync[1];
  assign w_start = r_state == IDLE && !w_rx_s;
  assign w_tick = r_state != IDLE && r_div == DIVW'(DIV - 1);
  assign w_dec = w_tick && r_os == OSW'(OVERSAMPLE / 2 + 1);
  assign w_maj = majority3({r_samp, w_rx_s});
  assign w_last = r_bit == BW'(r_state == DATA ? DATA_BITS - 1 : STOP_BITS - 1);

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_sync <= 2'b11;
      r_div <= '0;
      r_os <= '0;
      r_samp <= '0;
    end else begin
      r_sync <= {r_sync[0], rx};
      r_div <= (w_start || w_tick) ? '0 : r_state != IDLE ? r_div + 1'b1 : r_div;
      r_os <= w_start ? '0 : w_tick ? (r_os == OSW'(OVERSAMPLE - 1) ? '0 : r_os + 1'b1) : r_os;
      if (w_tick && (r_os == OSW'(OVERSAMPLE / 2 - 1) || r_os == OSW'(OVERSAMPLE / 2)))
        r_samp <= {r_samp[0], w_rx_s};
    end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_next;

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:             w_next = w_rx_s ? IDLE : START;
      START:            if (w_dec) w_next = w_maj ? IDLE : DATA;
      DATA:             if (w_dec && w_last) w_next = P_MODE != NONE ? uart_pkg::PARITY : STOP;
      uart_pkg::PARITY: if (w_dec) w_next = STOP;
      STOP:             if (w_dec && w_last) w_next = PUSH;
      PUSH:             w_next = w_break ? BREAK_WAIT : IDLE;
      BREAK_WAIT:       if (w_rx_s) w_next = IDLE;
      default:          w_next = IDLE;
    endcase
  end

  // an all-zero frame with a low first stop bit is a line break, not data
  always_comb begin
    w_break = r_state == PUSH && r_data == '0 && (P_MODE == NONE || !r_par) && !r_stop0;
    w_push = r_state == PUSH && !w_break;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_bit <= '0;
      r_data <= '0;
      r_par <= 1'b0;
      r_par_err <= 1'b0;
      r_frame_err <= 1'b0;
      r_stop0 <= 1'b0;
    end else begin
      r_bit <= r_state != w_next ? '0 : w_dec ? r_bit + 1'b1 : r_bit;
      if (w_start) begin
        r_par <= 1'b0;
        r_par_err <= 1'b0;
        r_frame_err <= 1'b0;
      end
      if (w_dec && r_state == DATA) r_data <= {w_maj, r_data[DATA_BITS-1:1]};
      if (w_dec && r_state == uart_pkg::PARITY) begin
        r_par <= w_maj;
        r_par_err <= (^r_data ^ w_maj) != (P_MODE == ODD);
      end
      if (w_dec && r_state == STOP) begin
        if (r_bit == '0) r_stop0 <= w_maj;
        if (!w_maj) r_frame_err <= 1'b1;
      end
    end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_overrun <= 1'b0;
    else r_overrun <= w_drop | (r_overrun & ~err_clear);

  uart_rx_fifo #(.WIDTH(DATA_BITS + 2), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_wr    (w_push),
    .i_rd    (rx_ready),
    .i_data  ({r_frame_err, r_par_err, r_data}),
    .o_data  (w_head),
    .o_valid (rx_valid),
    .o_drop  (w_drop),
    .o_count (fifo_count)
  );

  assign {rx_frame_err, rx_parity_err, rx_data} = w_head;
  assign rx_overrun = r_overrun;
  assign rx_break = w_break;
endmodule

// File: doc/uart_rx_cfg.md
Name: uart_rx_cfg

Overview:
Parametrised UART receiver for the host link. It supports configurable data width, parity, stop bits and oversampling, with 3-sample majority voting. Received words go into a small FIFO with a valid/ready output handshake. It flags per-word framing and parity errors, a sticky overrun, and line break. It sits between the board RX pin and the command decoder, and replaces the fixed 8N1 receiver.

Parameters:
CLK_FREQ_HZ, 100_000_000, system clock frequency
BAUD_RATE, 115200, line rate
DATA_BITS, 8, payload bits per frame, legal 5..9, LSB first
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, 1 or 2
OVERSAMPLE, 16, sample ticks per bit, even, >= 8
FIFO_DEPTH, 4, output FIFO entries, power of 2, >= 2

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
rx  in  1  asynchronous serial input, idle high
rx_data  out  DATA_BITS  FIFO head payload
rx_valid  out  1  FIFO non-empty
rx_ready  in  1  consumer accepts head when rx_valid && rx_ready
rx_frame_err  out  1  head word had stop-bit error; qualified by rx_valid
rx_parity_err  out  1  head word parity mismatch; qualified by rx_valid; 0 when PARITY = 0
rx_overrun  out  1  sticky: a word was dropped because the FIFO was full
err_clear  in  1  clears rx_overrun
rx_break  out  1  one-cycle pulse when a break is detected
fifo_count  out  $clog2(FIFO_DEPTH)+1  occupancy

Behaviour:
- Reset (async, rst_n low): sync flops go to 1, FSM to IDLE, FIFO empty, tick counter 0. All outputs are 0 except fifo_count = 0. Reset mid-frame discards the partial frame.
- Synchroniser: 2 flops; all logic uses the second stage rx_s.
- Tick: DIV = CLK_FREQ_HZ / (BAUD_RATE*OVERSAMPLE), elaboration error if DIV < 2. The tick counter runs only while not IDLE and restarts at 0 on start detection.
- Sampling: each bit uses the majority of rx_s at ticks OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1 of that bit. The bit decision is made on the tick OVERSAMPLE/2+1. Bit boundary is every OVERSAMPLE ticks.
- FSM:
  - IDLE -> START on rx_s == 0.
  - START: majority 1 returns to IDLE (glitch, nothing pushed); majority 0 -> DATA.
  - DATA: shift DATA_BITS bits, LSB first -> PARITY if PARITY != 0, else STOP.
  - PARITY: compute parity_err. Odd mode requires the XOR of data and parity bit to be 1; even mode requires it to be 0. Then -> STOP.
  - STOP: sample STOP_BITS bits; frame_err = any stop majority 0 -> PUSH.
  - PUSH (1 cycle): if data == 0, parity bit == 0 (when present) and the first stop bit is 0, it is a break. Pulse rx_break, push nothing, -> BREAK_WAIT. Otherwise write {frame_err, parity_err, data} -> IDLE.
  - BREAK_WAIT -> IDLE when rx_s == 1.
- Second stop bit: with STOP_BITS = 2, sampling begins immediately after the first stop decision window. The next start edge is accepted only in IDLE.
- Latency: rx_valid rises the cycle after PUSH. That is 2 clk after the last stop-bit decision tick when the FIFO was empty.
- FIFO: first-word-fall-through, registered pointers and count. The head is popped on rx_valid && rx_ready.
- Write while full with no pop: word dropped, rx_overrun set.
- Write while full with simultaneous pop: write accepted, no overrun, count unchanged.
- Pop while empty: ignored.
- err_clear and a new overrun in the same cycle: overrun wins (stays 1).

Decomposition:
- uart_pkg holds:
  - parity_t enum (NONE, ODD, EVEN)
  - rx_state_t enum (IDLE, START, DATA, PARITY, STOP, PUSH, BREAK_WAIT)
  - function calc_div(clk, baud, os)
  - function majority3
- One sub-module, uart_rx_fifo, parametrised on width and depth, with count output. The entry width is DATA_BITS+2.

Test Plan (CLK_FREQ_HZ = 3_200_000, BAUD_RATE = 100_000, OVERSAMPLE = 16 -> DIV 2, 32 clk/bit):
- 8N1, send 0xA5, rx_ready = 1 -> one rx_valid beat with rx_data = 0xA5, both error flags 0, fifo_count back to 0.
- PARITY = 2 (8E1), send 0x07 with correct parity 1 then wrong parity 0 -> two words, rx_parity_err 0 then 1.
- Stop bit forced low on 0x3C -> word 0x3C with rx_frame_err = 1. Hold rx low 20 bit times -> single rx_break pulse, no push, FSM idles only after rx returns high.
- rx_ready = 0, send 5 bytes 0x01..0x05 with FIFO_DEPTH = 4 -> fifo_count = 4, rx_overrun = 1, drain yields 0x01..0x04. err_clear clears overrun.
- Single-sample glitch (1 clk low) on the start bit, and a 1-tick spike inside data bit 3 of 0x00 -> no frame from the glitch, data 0x00 (majority rejects spike).
- Assert rst_n low mid-DATA of 0x55, then release and send 0x5A -> only 0x5A received, all outputs 0 during reset.
